// File: rtl/sum4_window_accum_if.sv
// Valid/ready bundle between the adder stage, the window accumulator and the next stage.
// The slave side is the accumulator; the master side drives samples and consumes results.
interface sum4_window_accum_if #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 13
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_total;
  logic [DATA_W-1:0] out_mean;

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_mean
  );

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_mean
  );
endinterface

// File: rtl/sum4_window_accum.sv
// Accumulates COUNT adder sums per window, then holds the total and truncated mean
// on a valid/ready output until consumed.
module sum4_window_accum #(
  parameter int DATA_W = 10,
  parameter int COUNT  = 8,
  parameter int CNT_W  = $clog2(COUNT),
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  sum4_window_accum_if.slave bus,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  total_reg;
  logic [DATA_W-1:0] mean_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;

  logic [ACC_W-1:0]  acc_next;
  logic              last_sample;

  // Only registered on an accept, so in_sum is never observed outside a transfer.
  always_comb begin
    acc_next = acc_reg + {{CNT_W{1'b0}}, bus.in_sum};
  end

  assign last_sample = (cnt_reg == CNT_W'(COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      total_reg     <= '0;
      mean_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else if (clear) begin
      // Result registers keep their last value; only the valid flag is withdrawn.
      state_reg     <= ST_ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            if (last_sample) begin
              total_reg     <= acc_next;
              mean_reg      <= acc_next[ACC_W-1:CNT_W];
              acc_reg       <= '0;
              cnt_reg       <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_HOLD;
            end else begin
              acc_reg <= acc_next;
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_ACCUM;
          end
        end
        default: begin
          state_reg     <= ST_ACCUM;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // in_ready depends on the state register alone, keeping inputs off any output path.
  assign bus.in_ready  = (state_reg == ST_ACCUM);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_total = total_reg;
  assign bus.out_mean  = mean_reg;
  assign sample_cnt    = cnt_reg;

endmodule

// File: tb/tb_sum4_window_accum.sv
// Randomised and directed stimulus for sum4_window_accum; a window-level reference
// model predicts every result and a negedge monitor scores the DUT against it.
module tb_sum4_window_accum;
  localparam int DATA_W = 10;
  localparam int COUNT  = 8;
  localparam int CNT_W  = $clog2(COUNT);
  localparam int ACC_W  = DATA_W + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic [CNT_W-1:0] sample_cnt;

  sum4_window_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  sum4_window_accum #(
    .DATA_W (DATA_W),
    .COUNT  (COUNT),
    .CNT_W  (CNT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: samples of the open window and totals awaiting consumption.
  int win_q[$];
  int exp_q[$];
  bit model_hold = 1'b0;

  // Snapshot of outputs taken just after an asynchronous reset edge.
  int   async_seq  = 0;
  int   async_seen = 0;
  logic async_valid;
  logic [ACC_W-1:0] async_total;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    int tot;
    if (async_seq != async_seen) begin
      check("async_rst_out_valid", async_valid, 0);
      check("async_rst_out_total", async_total, 0);
      async_seen = async_seq;
    end
    if (!rst_n) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_total", bus.out_total, 0);
      check("rst_out_mean", bus.out_mean, 0);
      check("rst_sample_cnt", sample_cnt, 0);
      win_q.delete();
      exp_q.delete();
      model_hold = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, !model_hold);
      check("out_valid", bus.out_valid, model_hold);
      check("sample_cnt", int'(sample_cnt), win_q.size());
      if (model_hold && exp_q.size() > 0) begin
        check("out_total", bus.out_total, exp_q[0]);
        check("out_mean", bus.out_mean, exp_q[0] / COUNT);
      end
      if (clear) begin
        win_q.delete();
        exp_q.delete();
        model_hold = 1'b0;
      end else if (!model_hold && bus.in_valid) begin
        win_q.push_back(int'(bus.in_sum));
        if (win_q.size() == COUNT) begin
          tot = 0;
          foreach (win_q[i]) tot += win_q[i];
          exp_q.push_back(tot);
          win_q.delete();
          model_hold = 1'b1;
        end
      end else if (model_hold && bus.out_ready) begin
        void'(exp_q.pop_front());
        model_hold = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one sample and hold it until the DUT takes it.
  task automatic send(input logic [DATA_W-1:0] s);
    int  n = 0;
    bit  taken;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    do begin
      @(negedge clk);
      taken = bus.in_ready && !clear;
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        $display("FAIL send_timeout: in_ready never accepted sample %0d", s);
        $fatal(1, "send timeout");
      end
    end while (!taken);
    bus.in_valid = 1'b0;
    bus.in_sum   = DATA_W'($urandom);
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Back-to-back window 1..8 with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= COUNT; i++) send(DATA_W'(i));
    idle(2);

    // Maximum adder output in every slot.
    for (int i = 0; i < COUNT; i++) send(DATA_W'(1020));
    idle(2);

    // Backpressure: result held while upstream keeps in_valid high.
    bus.out_ready = 1'b0;
    for (int i = 0; i < COUNT; i++) send(DATA_W'(100));
    bus.in_valid = 1'b1;
    bus.in_sum   = DATA_W'(55);
    idle(5);
    bus.out_ready = 1'b1;
    for (int i = 0; i < COUNT; i++) send(DATA_W'(55));
    idle(2);

    // Clear mid-window drops the sample presented alongside it.
    for (int i = 0; i < 3; i++) send(DATA_W'(50));
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = DATA_W'(999);
    idle(1);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < COUNT; i++) send(DATA_W'(7));
    idle(2);

    // Reset while a result is being held.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= COUNT; i++) send(DATA_W'(i));
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    async_valid = bus.out_valid;
    async_total = bus.out_total;
    async_seq++;
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);

    // Gapped input: one idle cycle between samples.
    for (int i = 0; i < COUNT; i++) begin
      send(DATA_W'(3));
      idle(1);
    end
    idle(2);

    // Random traffic with occasional clears and backpressure.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_sum    = DATA_W'($urandom_range(0, 1020));
      bus.out_ready = ($urandom % 3) != 0;
      clear         = ($urandom % 40) == 0;
      idle(1);
    end
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sum4_window_accum.md
Name: sum4_window_accum

Overview:
- Downstream consumer of the four-operand 8-bit adder's 10-bit `sum_out`.
- Accepts one sum per valid/ready transfer and accumulates a window of COUNT samples.
- At window end, presents the window total and the truncated mean to the next stage through a valid/ready output.
- Holds the result until it is consumed, then starts a new window.

Parameters:
- DATA_W, 10, width of incoming sum (matches adder output).
- COUNT, 8, samples per window; power of two, 2..256.
- CNT_W, log2(COUNT), width of sample counter and mean shift.
- ACC_W, DATA_W+CNT_W, accumulator/total width; overflow impossible by construction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_sum carries a sample
- in_ready  output  1  block can accept a sample this cycle
- in_sum  input  DATA_W  unsigned sum from adder stage
- clear  input  1  synchronous window abort/restart
- out_valid  output  1  out_total/out_mean valid
- out_ready  input  1  downstream accepts result
- out_total  output  ACC_W  sum of the COUNT window samples
- out_mean  output  DATA_W  out_total >> CNT_W (truncate)
- sample_cnt  output  CNT_W  samples accepted in current window

Behaviour:
- Reset (rst_n low, async):
  - State=ACCUM; accumulator, sample_cnt, out_total, out_mean = 0.
  - out_valid=0; in_ready=1 from the first cycle after deassertion.
  - Reset mid-window or mid-HOLD discards all data; no partial result is emitted.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready: acc <= acc + in_sum (unsigned, zero-extended to ACC_W); sample_cnt increments.
  - On accepting the sample where sample_cnt==COUNT-1:
    - Register out_total <= acc + in_sum and out_mean <= (acc + in_sum) >> CNT_W.
    - Zero acc and sample_cnt (sample_cnt wraps to 0); move to HOLD.
    - out_valid=1 the cycle after that accept (1-cycle latency from last sample).
- HOLD:
  - in_ready=0, out_valid=1.
  - out_total and out_mean stay stable until the handshake.
  - On out_valid & out_ready, go to ACCUM; out_valid=0 and in_ready=1 the next cycle.
  - No input is accepted in the handoff cycle (in_ready is already 0), so max throughput is COUNT samples per COUNT+1 cycles.
- clear (synchronous, highest priority after reset, any state):
  - Next state ACCUM; acc and sample_cnt = 0; out_valid=0.
  - Any sample presented in the clear cycle is dropped even if in_valid & in_ready.
  - An unconsumed HOLD result is discarded.
  - out_total and out_mean keep their last values but are invalid.
- in_valid while in_ready=0: ignored; upstream must hold the sample.
- out_ready while out_valid=0: no effect.
- in_sum is sampled only on accept; X on in_sum at other times must not propagate.
- All outputs are registered except in_ready, which is decoded from the state register only (no combinational path from any input).

Test Plan:
- Reset release, COUNT=8, eight back-to-back accepts of in_sum=1..8 with out_ready=1:
  - out_valid rises the cycle after the 8th accept with out_total=36, out_mean=4.
  - Handshake completes the same cycle; in_ready=1 the following cycle.
- Eight accepts of in_sum=1020 (adder max, 4*255):
  - out_total=8160 (13 bits, no overflow), out_mean=1020.
- Backpressure: complete a window of in_sum=100, then hold out_ready=0 for 5 cycles with in_valid=1 throughout:
  - out_valid=1, out_total=800, out_mean=100 stable all 5 cycles; in_ready=0, no accepts.
  - Raise out_ready: out_valid drops next cycle, first new sample accepted the cycle after.
- Clear mid-window:
  - Accept 3 samples of 50, then assert clear for 1 cycle with in_valid=1, in_sum=999 → 999 dropped, sample_cnt=0.
  - Then 8 samples of 7 → out_total=56, out_mean=7.
- Reset mid-HOLD: with out_valid=1 and out_total=36, pulse rst_n low → out_valid=0 and out_total=0 immediately (async), sample_cnt=0, in_ready=1 after release.
- Gapped input: 8 samples of 3 with in_valid low on alternate cycles → sample_cnt increments only on accepts; out_total=24, out_mean=3; sample_cnt=0 after the final accept.
